// File: rtl/mwave_timer_fsm.sv
// Microwave cooking controller: W-bit tick-driven countdown with load/start/pause/cancel/door FSM.
// Define MWR_BEEP_EN to hold an end-of-cook beep for BEEP_TICKS ticks; otherwise DONE lasts one cycle.
module mwave_timer_fsm #(
  parameter int W          = 8,
  parameter int BEEP_TICKS = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic [W-1:0] tin,
  input  logic         load,
  input  logic         start,
  input  logic         stop,
  input  logic         door,
  output logic         p,
  output logic         busy,
  output logic [W-1:0] remain,
  output logic         done,
  output logic         beep
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  if (BEEP_TICKS < 1) begin : g_bad_beep_ticks
    $error("BEEP_TICKS must be at least 1");
  end

  state_t         state_q, state_d;
  logic [W-1:0]   remain_q, remain_d;
  logic           p_q, p_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

`ifdef MWR_BEEP_EN
  localparam int             BW        = $clog2(BEEP_TICKS + 1);
  localparam logic [BW-1:0]  BEEP_LAST = BW'(BEEP_TICKS - 1);
  logic [BW-1:0]  beep_cnt_q, beep_cnt_d;
  logic           beep_q, beep_d;
`endif

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
`ifdef MWR_BEEP_EN
    beep_cnt_d = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (load) begin
          remain_d = tin;
        end else if (start && (remain_q != '0) && !door) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Interlock wins over the time base: no decrement on the pausing cycle.
        if (stop || door) begin
          state_d = S_PAUSE;
        end else if (tick) begin
          remain_d = remain_q - W'(1);
          if (remain_q == W'(1)) state_d = S_DONE;
        end
      end
      S_PAUSE: begin
        if (stop) begin
          state_d  = S_IDLE;
          remain_d = '0;
        end else if (start && !door) begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
`ifdef MWR_BEEP_EN
        // Counter starts at 0 on entry; only ticks sampled while in DONE advance it.
        beep_cnt_d = beep_cnt_q;
        if (stop) begin
          state_d = S_IDLE;
        end else if (tick) begin
          if (beep_cnt_q == BEEP_LAST) state_d = S_IDLE;
          else                         beep_cnt_d = beep_cnt_q + BW'(1);
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase

    p_d    = (state_d == S_RUN);
    busy_d = (state_d == S_RUN) || (state_d == S_PAUSE);
    done_d = (state_d == S_DONE) && (state_q != S_DONE);
`ifdef MWR_BEEP_EN
    beep_d = (state_d == S_DONE);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      remain_q <= '0;
      p_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef MWR_BEEP_EN
      beep_cnt_q <= '0;
      beep_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      p_q      <= p_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef MWR_BEEP_EN
      beep_cnt_q <= beep_cnt_d;
      beep_q     <= beep_d;
`endif
    end
  end

  assign p      = p_q;
  assign busy   = busy_q;
  assign remain = remain_q;
  assign done   = done_q;
`ifdef MWR_BEEP_EN
  assign beep   = beep_q;
`else
  assign beep   = 1'b0;
`endif

endmodule

// File: tb/tb_mwave_timer_fsm.sv
// Directed bench for mwave_timer_fsm: W=8 instance plus a W=4 instance for the full-range case.
module tb_mwave_timer_fsm;

  logic       clk = 1'b0;
  logic       rst, tick, load, start, stop, door;
  logic [7:0] tin;
  logic       p, busy, done, beep;
  logic [7:0] remain;
  logic       p4, busy4, done4, beep4;
  logic [3:0] remain4;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  mwave_timer_fsm #(.W(8), .BEEP_TICKS(3)) dut (
    .clk(clk), .rst(rst), .tick(tick), .tin(tin), .load(load), .start(start),
    .stop(stop), .door(door), .p(p), .busy(busy), .remain(remain), .done(done), .beep(beep)
  );

  mwave_timer_fsm #(.W(4), .BEEP_TICKS(3)) dut4 (
    .clk(clk), .rst(rst), .tick(tick), .tin(tin[3:0]), .load(load), .start(start),
    .stop(stop), .door(door), .p(p4), .busy(busy4), .remain(remain4), .done(done4), .beep(beep4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    rst = 1'b0; tick = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0; door = 1'b0; tin = 8'd0;
  endtask

  task automatic do_reset();
    quiet();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic load_and_start(input logic [7:0] n, input logic t);
    tin = n; load = 1'b1;
    step();
    load = 1'b0; start = 1'b1; tick = t;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    tin = 8'd9; load = 1'b1;
    step();
    do_reset();
    checks++;
    if ({p, busy, done, beep} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b want 0000", {p, busy, done, beep});
    end
    checks++;
    if (remain !== 8'd0) begin
      errors++; $display("FAIL reset_remain got %0d want 0", remain);
    end
  endtask

  task automatic test_basic();
    do_reset();
    tin = 8'd3; load = 1'b1;
    step();
    load = 1'b0;
    checks++;
    if (remain !== 8'd3 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_load remain=%0d busy=%b want 3 0", remain, busy);
    end
    start = 1'b1; tick = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if ({p, busy} !== 2'b11 || remain !== 8'd3) begin
      errors++; $display("FAIL basic_start p=%b busy=%b remain=%0d want 1 1 3", p, busy, remain);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (p !== 1'b1 || remain !== 8'(2 - i) || done !== 1'b0) begin
        errors++; $display("FAIL basic_count%0d p=%b remain=%0d done=%b want 1 %0d 0", i, p, remain, done, 2 - i);
      end
    end
    step();
    checks++;
    if ({p, busy, done} !== 3'b001 || remain !== 8'd0) begin
      errors++; $display("FAIL basic_done p/busy/done=%b remain=%0d want 001 0", {p, busy, done}, remain);
    end
    step();
    checks++;
`ifdef MWR_BEEP_EN
    if (done !== 1'b0 || beep !== 1'b1) begin
      errors++; $display("FAIL basic_after done=%b beep=%b want 0 1", done, beep);
    end
`else
    if ({p, busy, done, beep} !== 4'b0000) begin
      errors++; $display("FAIL basic_after flags=%b want 0000", {p, busy, done, beep});
    end
`endif
    tick = 1'b0;
  endtask

  task automatic test_door();
    do_reset();
    load_and_start(8'd5, 1'b1);
    step(); step();
    checks++;
    if (remain !== 8'd3 || p !== 1'b1) begin
      errors++; $display("FAIL door_pre remain=%0d p=%b want 3 1", remain, p);
    end
    door = 1'b1;
    step();
    checks++;
    if ({p, busy} !== 2'b01 || remain !== 8'd3) begin
      errors++; $display("FAIL door_open p=%b busy=%b remain=%0d want 0 1 3", p, busy, remain);
    end
    start = 1'b1;
    step();
    checks++;
    if (p !== 1'b0 || remain !== 8'd3) begin
      errors++; $display("FAIL door_start_ignored p=%b remain=%0d want 0 3", p, remain);
    end
    door = 1'b0;
    step();
    start = 1'b0;
    checks++;
    if (p !== 1'b1 || remain !== 8'd3) begin
      errors++; $display("FAIL door_resume p=%b remain=%0d want 1 3", p, remain);
    end
    step(); step();
    checks++;
    if (p !== 1'b1 || remain !== 8'd1 || done !== 1'b0) begin
      errors++; $display("FAIL door_run p=%b remain=%0d done=%b want 1 1 0", p, remain, done);
    end
    step();
    checks++;
    if (p !== 1'b0 || done !== 1'b1 || remain !== 8'd0) begin
      errors++; $display("FAIL door_done p=%b done=%b remain=%0d want 0 1 0", p, done, remain);
    end
    tick = 1'b0;
  endtask

  task automatic test_cancel();
    do_reset();
    load_and_start(8'd4, 1'b0);
    stop = 1'b1;
    step();
    checks++;
    if ({p, busy} !== 2'b01 || remain !== 8'd4) begin
      errors++; $display("FAIL cancel_pause p=%b busy=%b remain=%0d want 0 1 4", p, busy, remain);
    end
    step();
    stop = 1'b0;
    checks++;
    if ({p, busy, done} !== 3'b000 || remain !== 8'd0) begin
      errors++; $display("FAIL cancel_idle flags=%b remain=%0d want 000 0", {p, busy, done}, remain);
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL cancel_nodone done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_zero_load();
    do_reset();
    load_and_start(8'd0, 1'b1);
    tick = 1'b0;
    checks++;
    if ({p, busy} !== 2'b00 || remain !== 8'd0) begin
      errors++; $display("FAIL zero_start p=%b busy=%b remain=%0d want 0 0 0", p, busy, remain);
    end
  endtask

  task automatic test_load_start_same();
    do_reset();
    tin = 8'd7; load = 1'b1; start = 1'b1;
    step();
    load = 1'b0; start = 1'b0;
    checks++;
    if (p !== 1'b0 || remain !== 8'd7) begin
      errors++; $display("FAIL load_start_same p=%b remain=%0d want 0 7", p, remain);
    end
  endtask

  task automatic test_w4_full();
    int cnt;
    bit seen;
    do_reset();
    tin = 8'd15; load = 1'b1;
    step();
    load = 1'b0;
    checks++;
    if (remain4 !== 4'hF) begin
      errors++; $display("FAIL w4_load got %0d want 15", remain4);
    end
    start = 1'b1; tick = 1'b1;
    step();
    start = 1'b0;
    cnt = 0; seen = 1'b0;
    if (p4) cnt++;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (p4) cnt++;
      if (done4) seen = 1'b1;
    end
    tick = 1'b0;
    checks++;
    if (!seen || cnt != 15 || remain4 !== 4'd0) begin
      errors++; $display("FAIL w4_cook done_seen=%0d p_cycles=%0d remain=%0d want 1 15 0", seen, cnt, remain4);
    end
  endtask

  task automatic test_stop_last();
    do_reset();
    load_and_start(8'd2, 1'b1);
    step();
    stop = 1'b1;
    step();
    stop = 1'b0; tick = 1'b0;
    checks++;
    if ({p, busy, done} !== 3'b010 || remain !== 8'd1) begin
      errors++; $display("FAIL stop_last flags=%b remain=%0d want 010 1", {p, busy, done}, remain);
    end
  endtask

  task automatic test_load_in_run();
    do_reset();
    load_and_start(8'd5, 1'b1);
    tin = 8'd9; load = 1'b1;
    step();
    load = 1'b0; tick = 1'b0;
    checks++;
    if (remain !== 8'd4 || p !== 1'b1) begin
      errors++; $display("FAIL load_in_run remain=%0d p=%b want 4 1", remain, p);
    end
  endtask

  task automatic test_sparse_tick();
    logic [7:0] exp_rem;
    do_reset();
    load_and_start(8'd2, 1'b0);
    for (int c = 1; c <= 8; c++) begin
      tick = (c % 4 == 0);
      step();
      exp_rem = (c < 4) ? 8'd2 : (c < 8) ? 8'd1 : 8'd0;
      checks++;
      if (remain !== exp_rem || p !== (c < 8)) begin
        errors++; $display("FAIL sparse_c%0d remain=%0d p=%b want %0d %0d", c, remain, p, exp_rem, c < 8);
      end
    end
    tick = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL sparse_done got %b want 1", done);
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    load_and_start(8'd6, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({p, busy} !== 2'b00 || remain !== 8'd0) begin
      errors++; $display("FAIL reset_mid p=%b busy=%b remain=%0d want 0 0 0", p, busy, remain);
    end
  endtask

`ifdef MWR_BEEP_EN
  task automatic test_beep();
    int cnt;
    do_reset();
    load_and_start(8'd1, 1'b1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (beep) cnt++;
    end
    tick = 1'b0;
    checks++;
    if (cnt != 3 || busy !== 1'b0) begin
      errors++; $display("FAIL beep_len got %0d busy=%b want 3 0", cnt, busy);
    end
    do_reset();
    load_and_start(8'd1, 1'b1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; tick = 1'b0;
    checks++;
    if (beep !== 1'b0) begin
      errors++; $display("FAIL beep_reset got %b want 0", beep);
    end
    do_reset();
    load_and_start(8'd1, 1'b1);
    step();
    tick = 1'b0; stop = 1'b1;
    step();
    stop = 1'b0;
    checks++;
    if (beep !== 1'b0) begin
      errors++; $display("FAIL beep_stop got %b want 0", beep);
    end
  endtask
`endif

  initial begin
    quiet();
    test_reset();
    test_basic();
    test_door();
    test_cancel();
    test_zero_load();
    test_load_start_same();
    test_w4_full();
    test_stop_last();
    test_load_in_run();
    test_sparse_tick();
    test_reset_mid_run();
`ifdef MWR_BEEP_EN
    test_beep();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
